// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle operand shifter with valid/ready handshakes.
//
// Accepts one operand per transaction and shifts it by up to STEP bit positions
// per clock. The result is presented on Op with out_valid until the consumer
// takes it. Supported modes are LSL, LSR, ASR and ROL.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds in_valid/Ip/amt/mode
// until in_ready. The block holds out_valid/Op until out_ready. in_ready and
// out_valid are never high together.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   block idle and able to accept (high only in IDLE)
//   Ip         operand, WIDTH bits, bit WIDTH-1 is the MSB
//   amt        requested shift amount, AW bits
//   mode       00 LSL, 01 LSR, 10 ASR, 11 ROL
//   out_valid  result valid on Op (high only in DONE)
//   out_ready  consumer accepts result
//   Op         result / working register
//   busy       high in SHIFT or DONE
//
// The state can be observed from outside as {busy, out_valid}:
// 00 = IDLE, 10 = SHIFT, 11 = DONE.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ip,
    input  logic [AW-1:0]    amt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Op,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
    localparam logic [AW-1:0] WM1_A   = AW'(WIDTH - 1);
    localparam logic [AW-1:0] STEP_A  = AW'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [1:0]       mode_q, mode_d;
    logic [AW-1:0]    rem_q, rem_d;

    logic [AW-1:0]      eff_amt;
    logic [AW-1:0]      step_amt;
    logic [WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0] rol_w;

    // Effective amount from the raw request. ASR saturates at WIDTH-1 because
    // by then every bit already equals the sign bit. ROL wraps, and since
    // WIDTH is a power of two the wrap is a mask.
    always_comb begin
        eff_amt = amt;
        case (mode)
            MODE_LSL, MODE_LSR: eff_amt = (amt > WIDTH_A) ? WIDTH_A : amt;
            MODE_ASR:           eff_amt = (amt > WM1_A) ? WM1_A : amt;
            MODE_ROL:           eff_amt = amt & WM1_A;
            default:            eff_amt = amt;
        endcase
    end

    // One step of the shift: s = min(STEP, rem).
    always_comb begin
        step_amt = (rem_q > STEP_A) ? STEP_A : rem_q;
        // Rotate: shift a doubled copy left, and take the upper half.
        rol_w    = {op_q, op_q} << step_amt;
        shifted  = op_q;
        case (mode_q)
            MODE_LSL: shifted = op_q << step_amt;
            MODE_LSR: shifted = op_q >> step_amt;
            MODE_ASR: shifted = $signed(op_q) >>> step_amt;
            MODE_ROL: shifted = rol_w[2*WIDTH-1:WIDTH];
            default:  shifted = op_q;
        endcase
    end

    // Next state and datapath updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = Ip;
                    mode_d  = mode;
                    rem_d   = eff_amt;
                    state_d = (eff_amt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                op_d  = shifted;
                rem_d = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            mode_q  <= MODE_LSL;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    // All outputs come from registers or state decode only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign Op        = op_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit combinational shifter.
- Accepts one operand with a shift amount and mode over a valid/ready handshake.
- Shifts the operand by up to STEP positions per clock, then presents the result on an output valid/ready handshake.
- Sits between operand-producing logic and the downstream consumer; supports logical left/right, arithmetic right and rotate-left.

Parameters:
- WIDTH, 8, operand width in bits; must be a power of 2 and ≥ 2.
- STEP, 1, maximum bit positions shifted per clock; 1 ≤ STEP ≤ WIDTH.
- AW, $clog2(WIDTH)+1, width of the amt port (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- Ip  in  WIDTH  operand; bit WIDTH-1 is the MSB.
- amt  in  AW  requested shift amount, 0..2^AW-1.
- mode  in  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- out_valid  out  1  result valid on Op.
- out_ready  in  1  consumer accepts result.
- Op  out  WIDTH  result / working register.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE, in_ready=1, out_valid=0, busy=0, Op=0, remaining count=0. Reset mid-operation abandons the transaction and returns no result.
- State machine IDLE / SHIFT / DONE:
  - IDLE: in_ready=1. On in_valid && in_ready, capture Ip into Op, latch mode, and load rem = effective amount. Go to SHIFT if rem>0, else DONE.
  - SHIFT: in_ready=0. Each clock, shift Op by s = min(STEP, rem) and set rem -= s. When rem reaches 0, go to DONE.
  - DONE: out_valid=1, Op held stable. On out_ready, go to IDLE; out_valid drops the next cycle. While out_ready is low, Op, out_valid and state hold indefinitely.
- Effective amount:
  - LSL and LSR: min(amt, WIDTH).
  - ASR: min(amt, WIDTH-1); result is identical to a WIDTH shift.
  - ROL: amt mod WIDTH.
- Per-step operation:
  - LSL: zero fill from the LSB.
  - LSR: zero fill from the MSB.
  - ASR: replicate the MSB of the current Op.
  - ROL: bits leaving the MSB enter at the LSB.
- Latency: accept at edge k; out_valid is high in the cycle after edge k+ceil(eff/STEP). amt 0 or effective 0 gives out_valid one cycle after accept.
- One transaction in flight; no new accept until back in IDLE. in_ready and out_valid are never high together, so there is no accept in the cycle out_ready completes.
- Op reflects intermediate values during SHIFT and holds the last result in IDLE until the next accept. Consumers sample Op only while out_valid=1.
- in_valid while not in IDLE is ignored; the producer holds the request until in_ready.
- mode and amt are sampled only at accept; changes afterwards have no effect.
- No combinational path from any input to any output; all outputs are registered or decoded from state.

Test Plan:
- WIDTH=8, STEP=1: Ip=8'b0000_0001, mode LSL, amt=3 → Op=8'b0000_1000; out_valid rises 4 cycles after accept; Op stable until out_ready.
- ASR with Ip=8'b1000_0000, amt=9 → effective 7 → Op=8'b1111_1111. LSR with Ip=8'b1000_0000, amt=15 → Op=8'b0000_0000 after 8 shift cycles.
- ROL with Ip=8'b1000_0001, amt=9 → effective 1 → Op=8'b0000_0011 after 1 shift cycle. amt=0 in any mode → Op=Ip, out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid=1 and Op unchanged throughout; in_ready=0; in_valid pulses are ignored. Release → IDLE next cycle, in_ready=1.
- Reset mid-SHIFT: LSL amt=6, assert rst_n=0 on the 3rd shift cycle → next cycle Op=0, out_valid=0, in_ready=1, busy=0; no result is ever presented.
- WIDTH=8, STEP=4: Ip=8'b1111_0000, mode LSR, amt=6 → two SHIFT cycles (4, then 2) → Op=8'b0000_0011; out_valid 3 cycles after accept.
